// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_adder_pkg -- default geometry and add/sub mode encoding. Rev 1.0
// ---------------------------------------------------------------------------
package pipelined_adder_pkg;

  localparam int   DEFAULT_WIDTH  = 8;
  localparam int   DEFAULT_STAGES = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/adder_segment.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_segment -- SEG-bit combinational ripple-carry slice of FullAdder cells. Rev 1.0
// ---------------------------------------------------------------------------
module adder_segment #(
  parameter int SEG = 2
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           cmsb_o
);

  logic [SEG:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    FullAdder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum_o[i]),
      .cout_o (carry[i+1])
    );
  end

  // Carry into the top bit feeds the signed-overflow detect of the last slice.
  assign cout_o = carry[SEG];
  assign cmsb_o = carry[SEG-1];

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// FullAdder -- single-bit full adder cell. Rev 1.0
// ---------------------------------------------------------------------------
module FullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_adder -- STAGES-deep carry-segmented add/sub with valid/ready flow control. Rev 1.0
// ---------------------------------------------------------------------------
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SEG = WIDTH / STAGES;

  // Operands are kept right-aligned: each stage consumes the low SEG bits and
  // shifts the remainder down; finished sum bits are shifted in from the top.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] ovf_q, ovf_d;
  logic [STAGES-1:0] adv;

  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = !valid_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] op_a, op_b, acc;
    logic             c_in, v_in;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout, seg_cmsb;

    if (k == 0) begin : g_head
      assign op_a = a;
      assign op_b = (sub == MODE_SUB) ? ~b : b;
      assign c_in = (sub == MODE_SUB) ? 1'b1 : cin;
      assign acc  = '0;
      assign v_in = in_valid;
    end else begin : g_body
      assign op_a = a_q[k-1];
      assign op_b = b_q[k-1];
      assign c_in = carry_q[k-1];
      assign acc  = sum_q[k-1];
      assign v_in = valid_q[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a_i    (op_a[SEG-1:0]),
      .b_i    (op_b[SEG-1:0]),
      .cin_i  (c_in),
      .sum_o  (seg_sum),
      .cout_o (seg_cout),
      .cmsb_o (seg_cmsb)
    );

    assign a_d[k]     = op_a >> SEG;
    assign b_d[k]     = op_b >> SEG;
    assign sum_d[k]   = (acc >> SEG) | (WIDTH'(seg_sum) << (WIDTH - SEG));
    assign carry_d[k] = seg_cout;
    assign ovf_d[k]   = seg_cout ^ seg_cmsb;
    assign valid_d[k] = v_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_d[k];
          // Payload only moves with a real beat, so a held output stays stable.
          if (valid_d[k]) begin
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
            ovf_q[k]   <= ovf_d[k];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0] && !reset;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign overflow  = ovf_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipelined_adder -- randomized self-checking bench with an arithmetic reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

  localparam int W  = 8;
  localparam int S  = 4;
  localparam int W2 = 16;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic          out_valid, out_ready = 1'b1, cout, overflow;
  logic [W-1:0]  a = '0, b = '0, sum;
  logic          in_valid2 = 1'b0, in_ready2, cin2 = 1'b0, sub2 = 1'b0;
  logic          out_valid2, out_ready2 = 1'b1, cout2, overflow2;
  logic [W2-1:0] a2 = '0, b2 = '0, sum2;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  pipelined_adder #(.WIDTH(W2), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .overflow(overflow2)
  );

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   dlv = 0;
  bit   lat_chk = 1'b0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Plain signed/unsigned arithmetic: result, carry/no-borrow, signed range overflow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    exp_t        e;
    int          sv;
    int unsigned u;
    if (s) begin
      sv  = int'($signed(x)) - int'($signed(y));
      e.c = (x >= y);
    end else begin
      sv  = int'($signed(x)) + int'($signed(y)) + int'(ci);
      u   = int'(x) + int'(y) + int'(ci);
      e.c = (u >= 2**W);
    end
    e.s = W'(sv);
    e.o = (sv > 2**(W-1) - 1) || (sv < -(2**(W-1)));
    e.t = 0;
    return e;
  endfunction

  // Scoreboard: push on acceptance, pop and compare on delivery, stability while stalled.
  initial begin
    exp_t         e;
    bit           stall;
    logic [W-1:0] hold_s;
    logic         hold_c, hold_o;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_sum", sum, hold_s);
          check("stall_cout", cout, hold_c);
          check("stall_ovf", overflow, hold_o);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) check("spurious_out", out_valid, 0);
          else begin
            e = q.pop_front();
            check("sum", sum, e.s);
            check("cout", cout, e.c);
            check("ovf", overflow, e.o);
            if (lat_chk) check("latency", cyc - e.t, S);
            dlv++;
          end
        end
        if (in_valid && in_ready) begin
          e   = model(a, b, cin, sub);
          e.t = cyc;
          q.push_back(e);
        end
        stall  = out_valid && !out_ready;
        hold_s = sum;
        hold_c = cout;
        hold_o = overflow;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat's accepting edge.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    int g;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("drive_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] es, input logic ec,
                            input logic eo, input int elat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check({nm, "_lat"}, n, elat);
    check({nm, "_sum"}, sum, es);
    check({nm, "_cout"}, cout, ec);
    check({nm, "_ovf"}, overflow, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int   acc, guard, base;
    bit   seen;

    m = model(8'hFF, 8'h01, 1'b0, 1'b0);
    check("model_ff01_s", m.s, 8'h00); check("model_ff01_c", m.c, 1); check("model_ff01_o", m.o, 0);
    m = model(8'h7F, 8'h01, 1'b0, 1'b0);
    check("model_7f01_s", m.s, 8'h80); check("model_7f01_c", m.c, 0); check("model_7f01_o", m.o, 1);
    m = model(8'h05, 8'h07, 1'b1, 1'b1);
    check("model_sub_s", m.s, 8'hFE); check("model_sub_c", m.c, 0); check("model_sub_o", m.o, 0);
    m = model(8'h80, 8'h01, 1'b0, 1'b1);
    check("model_sub2_s", m.s, 8'h7F); check("model_sub2_c", m.c, 1); check("model_sub2_o", m.o, 1);

    repeat (3) begin
      @(negedge clk);
      check("in_ready_in_reset", in_ready, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", overflow, 0);
    @(posedge clk); #1;

    lat_chk = 1'b1;
    drive(8'hFF, 8'h01, 1'b0, 1'b0); expect_out("wrap", 8'h00, 1'b1, 1'b0, S);
    drive(8'h7F, 8'h01, 1'b0, 1'b0); expect_out("sovf", 8'h80, 1'b0, 1'b1, S);
    drive(8'h05, 8'h07, 1'b1, 1'b1); expect_out("subb", 8'hFE, 1'b0, 1'b0, S);

    // Back-to-back stream into a stalled output.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    base      = dlv;
    fork
      begin
        for (int i = 0; i < 8; i++) drive(8'(i * 37 + 3), 8'(i * 91 + 5), 1'(i), 1'(i >> 1));
      end
      begin
        acc  = 0;
        seen = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (in_valid && !in_ready && !seen) begin
            check("fill_accepts", acc, S);
            seen = 1'b1;
          end
          if (in_valid && in_ready) acc++;
        end
        check("in_ready_dropped", seen, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while (dlv - base < 8 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("stream_delivered", dlv - base, 8);

    // Flush three in-flight beats with a one-cycle reset.
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    drive(8'h93, 8'h44, 1'b1, 1'b0);
    drive(8'h10, 8'h20, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("in_ready_mid_reset", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1);
    check("flush_sum", sum, 0);
    check("flush_cout", cout, 0);
    check("flush_ovf", overflow, 0);
    check("flush_valid", out_valid, 0);
    repeat (4) begin
      @(negedge clk);
      check("flush_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    lat_chk = 1'b1;
    drive(8'hC8, 8'h64, 1'b1, 1'b0); expect_out("post_reset", 8'h2D, 1'b1, 1'b0, S);
    lat_chk = 1'b0;

    // Single-stage 16-bit instance.
    a2 = 16'h8000; b2 = 16'h8000; cin2 = 1'b1; sub2 = 1'b0; in_valid2 = 1'b1;
    @(negedge clk);
    check("s1_in_ready", in_ready2, 1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    check("s1_valid", out_valid2, 1);
    check("s1_sum", sum2, 16'h0001);
    check("s1_cout", cout2, 1);
    check("s1_ovf", overflow2, 1);
    @(posedge clk); #1;

    // Random traffic with random back-pressure.
    acc   = 0;
    guard = 0;
    while (acc < 10000 && guard < 80000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      guard++;
    end
    check("random_beats", acc, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (q.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
